branch_hazard_ctrl: RTL and testbench
=====================================

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 issue_valid  input  1  Producer instruction enters EX this cycle.
REQ-003 issue_rd  input  5  Destination register of the issuing producer.
REQ-004 issue_wb  input  1  Issuing producer writes a register.
REQ-005 issue_fp  input  1  Issuing producer's destination is in the FP register file.
REQ-006 kill_valid, kill_rd[4:0], kill_fp  input  1/5/1  Squashed producer that will never write back.
REQ-007 wb_valid, rdwb[4:0], fw_wb  input  1/5/1  Writeback strobe, register and FP class.
REQ-008 br_valid  input  1  Branch is present in ID.
REQ-009 rs1id, rs2id  input  5 each  Branch source registers.
REQ-010 float_read  input  2  Operand class: bit1 applies to rs1, bit0 to rs2; 1 = FP.
REQ-011 fa, fb  output  1 each  Select the WB-forwarded value for rs1 / rs2.
REQ-012 stall  output  1  Hold ID/IF this cycle.
REQ-013 stall_err  output  1  Sticky watchdog flag.
REQ-014 stall_cnt  output  8  Length of the current stall run.

Function
REQ-015 The block SHALL keep one pending bit per register: 32 integer entries, plus 32 FP entries when FP support is configured.
REQ-016 A pending bit SHALL be set on the cycle after a producer issues with issue_valid and issue_wb asserted, for the entry selected by issue_rd and issue_fp, when issue_rd != 0.
REQ-017 A pending bit SHALL be cleared on the cycle after a matching writeback (wb_valid, rdwb, fw_wb) or a matching kill (kill_valid, kill_rd, kill_fp).
REQ-018 If a set and a clear hit the same entry in the same cycle, the set SHALL win.
REQ-019 Register 0 SHALL never be pending, never forwarded and never cause a stall.
REQ-020 fa SHALL equal wb_valid && rdwb != 0 && rdwb == rs1id && (float_read[1] == fw_wb), combinationally; fb SHALL follow the same rule using rs2id and float_read[0].
REQ-021 An operand SHALL be hazardous when all of the following hold: its register is non-zero; it is not being forwarded; and either its entry is pending or a same-class issue this cycle targets it.
REQ-022 stall SHALL equal br_valid && (hazard on rs1 || hazard on rs2), combinationally.
REQ-023 The block SHALL implement a two-state FSM:
- RUN moves to STALL when stall = 1.
- STALL moves to RUN when stall = 0.
REQ-024 stall_cnt SHALL be 0 in RUN, SHALL increment on each STALL cycle, SHALL saturate at 255, and SHALL clear on the return to RUN.
REQ-025 stall_err SHALL set when stall_cnt reaches 255 and SHALL clear only on reset.

Reset
REQ-026 While rst_n = 0 the block SHALL asynchronously clear every pending bit, return the FSM to RUN, and hold stall_cnt = 0 and stall_err = 0.
REQ-027 A reset asserted during a stall SHALL take effect immediately and SHALL force the outputs to stall = 0, fa = 0 and fb = 0.

Configuration
REQ-028 When BR_FWD_FLOAT_EN is defined, the block SHALL include the FP scoreboard and use class matching as specified in REQ-016 through REQ-021.
REQ-029 When BR_FWD_FLOAT_EN is undefined, the block SHALL:
- omit the FP scoreboard;
- ignore issue_fp, kill_fp, fw_wb and float_read;
- match on register number only.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Issue rd=5 (int); one cycle later a branch reads rs1=5 with no writeback -> stall=1 and stall_cnt counts 1, 2, 3 until the writeback.
- Writeback rd=5 in the same cycle as the branch reads rs1=5 -> fa=1, stall=0, and the pending bit is cleared the next cycle.
- Issue rd=7 and kill rd=7 in the same cycle -> entry 7 remains pending; a later kill rd=7 clears it and stall drops.
- With BR_FWD_FLOAT_EN defined, an FP rd=3 is pending and the branch reads integer rs2=3 -> stall=0 and fb=0.
- Hold the pending entry for 300 cycles -> stall_cnt saturates at 255, stall_err=1, and stall_err persists after the stall ends.
- Assert rst_n=0 mid-stall -> stall, stall_cnt and stall_err are 0 immediately and all entries are cleared.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: branch operand scoreboard, WB forwarding select, stall FSM and watchdog.
// Define BR_FWD_FLOAT_EN to add the FP register scoreboard and class-matched lookups.
module branch_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       issue_wb,
    input  logic       issue_fp,
    input  logic       kill_valid,
    input  logic [4:0] kill_rd,
    input  logic       kill_fp,
    input  logic       wb_valid,
    input  logic [4:0] rdwb,
    input  logic       fw_wb,
    input  logic       br_valid,
    input  logic [4:0] rs1id,
    input  logic [4:0] rs2id,
    input  logic [1:0] float_read,
    output logic       fa,
    output logic       fb,
    output logic       stall,
    output logic       stall_err,
    output logic [7:0] stall_cnt
);
    typedef enum logic {RUN, STALL} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic [31:0] r_pend_int, w_pend_int_nxt;
    logic        w_ifp, w_kfp, w_wfp;
    logic [1:0]  w_fr;
    logic        w_pend1, w_pend2, w_fa, w_fb, w_haz1, w_haz2, w_stall;

    // Clears from writeback/kill apply first so a same-cycle issue keeps the entry pending.
    function automatic logic [31:0] f_next(input logic [31:0] p, input logic s, input logic [4:0] s_rd,
                                           input logic c1, input logic [4:0] c1_rd,
                                           input logic c2, input logic [4:0] c2_rd);
        logic [31:0] clr, set;
        clr = ({31'd0, c1} << c1_rd) | ({31'd0, c2} << c2_rd);
        set = {31'd0, s} << s_rd;
        return ((p & ~clr) | set) & ~32'd1;
    endfunction

`ifdef BR_FWD_FLOAT_EN
    logic [31:0] r_pend_fp, w_pend_fp_nxt;

    assign w_ifp = issue_fp;
    assign w_kfp = kill_fp;
    assign w_wfp = fw_wb;
    assign w_fr  = float_read;
    assign w_pend_fp_nxt = f_next(r_pend_fp, issue_valid & issue_wb & w_ifp, issue_rd,
                                  wb_valid & w_wfp, rdwb, kill_valid & w_kfp, kill_rd);
    assign w_pend1 = w_fr[1] ? r_pend_fp[rs1id] : r_pend_int[rs1id];
    assign w_pend2 = w_fr[0] ? r_pend_fp[rs2id] : r_pend_int[rs2id];

    // FP pending bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_pend_fp <= '0;
        else        r_pend_fp <= w_pend_fp_nxt;
`else
    logic w_unused;

    assign w_unused = ^{issue_fp, kill_fp, fw_wb, float_read};
    assign w_ifp   = 1'b0;
    assign w_kfp   = 1'b0;
    assign w_wfp   = 1'b0;
    assign w_fr    = 2'b00;
    assign w_pend1 = r_pend_int[rs1id];
    assign w_pend2 = r_pend_int[rs2id];
`endif

    assign w_pend_int_nxt = f_next(r_pend_int, issue_valid & issue_wb & ~w_ifp, issue_rd,
                                   wb_valid & ~w_wfp, rdwb, kill_valid & ~w_kfp, kill_rd);

    assign w_fa = wb_valid && rdwb != 5'd0 && rdwb == rs1id && (w_fr[1] == w_wfp);
    assign w_fb = wb_valid && rdwb != 5'd0 && rdwb == rs2id && (w_fr[0] == w_wfp);

    assign w_haz1 = rs1id != 5'd0 && !w_fa &&
                    (w_pend1 || (issue_valid && issue_wb && issue_rd == rs1id && w_ifp == w_fr[1]));
    assign w_haz2 = rs2id != 5'd0 && !w_fb &&
                    (w_pend2 || (issue_valid && issue_wb && issue_rd == rs2id && w_ifp == w_fr[0]));
    assign w_stall = br_valid && (w_haz1 || w_haz2);

    assign fa        = rst_n & w_fa;
    assign fb        = rst_n & w_fb;
    assign stall     = rst_n & w_stall;
    assign stall_cnt = r_cnt;
    assign stall_err = r_err;

    // Integer pending bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_pend_int <= '0;
        else        r_pend_int <= w_pend_int_nxt;

    // Stall FSM next state, run-length counter with saturation, sticky watchdog
    always_comb begin
        w_state_nxt = w_stall ? STALL : RUN;
        w_cnt_nxt   = !w_stall ? 8'd0 : (r_state == RUN ? 8'd1 : (r_cnt == 8'd255 ? r_cnt : r_cnt + 8'd1));
        w_err_nxt   = r_err | (w_cnt_nxt == 8'd255);
    end

    // Stall FSM state, counter and watchdog registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed scenarios plus randomized traffic against a scoreboard model.
module tb_branch_hazard_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       issue_valid, issue_wb, issue_fp, kill_valid, kill_fp, wb_valid, fw_wb, br_valid;
    logic [4:0] issue_rd, kill_rd, rdwb, rs1id, rs2id;
    logic [1:0] float_read;
    logic       fa, fb, stall, stall_err;
    logic [7:0] stall_cnt;

`ifdef BR_FWD_FLOAT_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    int nvec = 0, nerr = 0;
    bit mp [2][32];
    int mcnt;
    bit merr;
    bit e_fa, e_fb, e_stall;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wb(issue_wb), .issue_fp(issue_fp),
        .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_fp(kill_fp),
        .wb_valid(wb_valid), .rdwb(rdwb), .fw_wb(fw_wb),
        .br_valid(br_valid), .rs1id(rs1id), .rs2id(rs2id), .float_read(float_read),
        .fa(fa), .fb(fb), .stall(stall), .stall_err(stall_err), .stall_cnt(stall_cnt)
    );

    function automatic int cl(input logic b);
        return FP ? int'(b) : 0;
    endfunction

    function automatic bit fwd(input logic [4:0] r, input int c);
        return wb_valid && rdwb == r && r != 0 && cl(fw_wb) == c;
    endfunction

    function automatic bit haz(input logic [4:0] r, input int c);
        return r != 0 && !fwd(r, c) &&
               (mp[c][r] || (issue_valid && issue_wb && issue_rd == r && cl(issue_fp) == c));
    endfunction

    function automatic void m_eval();
        e_fa    = rst_n && fwd(rs1id, cl(float_read[1]));
        e_fb    = rst_n && fwd(rs2id, cl(float_read[0]));
        e_stall = rst_n && br_valid && (haz(rs1id, cl(float_read[1])) || haz(rs2id, cl(float_read[0])));
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++)
                mp[c][r] = 1'b0;
        mcnt = 0;
        merr = 1'b0;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_wb = 0; issue_fp = 0;
        kill_valid = 0; kill_rd = 0; kill_fp = 0;
        wb_valid = 0; rdwb = 0; fw_wb = 0;
        br_valid = 0; rs1id = 0; rs2id = 0; float_read = 0;
    endtask

    task automatic tick();
        m_eval();
        @(posedge clk);
        if (!rst_n) m_reset();
        else begin
            if (kill_valid) mp[cl(kill_fp)][kill_rd] = 1'b0;
            if (wb_valid) mp[cl(fw_wb)][rdwb] = 1'b0;
            if (issue_valid && issue_wb && issue_rd != 0) mp[cl(issue_fp)][issue_rd] = 1'b1;
            mcnt = e_stall ? (mcnt == 255 ? 255 : mcnt + 1) : 0;
            if (mcnt == 255) merr = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        m_reset();
        wb_valid = 1; rdwb = 4; rs1id = 4; rs2id = 4; br_valid = 1;
        issue_valid = 1; issue_wb = 1; issue_rd = 6; rs2id = 6;
        #12;
        nvec++;
        if ({fa, fb, stall, stall_cnt, stall_err} !== 12'd0) begin
            nerr++; $display("FAIL reset_hold {fa,fb,stall,cnt,err} got=%h want=000", {fa, fb, stall, stall_cnt, stall_err});
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        #1;
        nvec++;
        if ({fa, fb, stall, stall_cnt, stall_err} !== 12'd0) begin
            nerr++; $display("FAIL reset_release {fa,fb,stall,cnt,err} got=%h want=000", {fa, fb, stall, stall_cnt, stall_err});
        end
    endtask

    task automatic test_stall_count();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 5;
        tick();
        idle();
        br_valid = 1; rs1id = 5;
        #1;
        nvec++;
        if (stall !== 1'b1 || stall_cnt !== 8'd0) begin
            nerr++; $display("FAIL stall_start stall=%b cnt=%0d want stall=1 cnt=0", stall, stall_cnt);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            nvec++;
            if (stall !== 1'b1 || stall_cnt !== 8'(k)) begin
                nerr++; $display("FAIL stall_count stall=%b cnt=%0d want stall=1 cnt=%0d", stall, stall_cnt, k);
            end
        end
        wb_valid = 1; rdwb = 5;
        #1;
        nvec++;
        if (fa !== 1'b1 || stall !== 1'b0 || fb !== 1'b0) begin
            nerr++; $display("FAIL wb_forward fa=%b fb=%b stall=%b want fa=1 fb=0 stall=0", fa, fb, stall);
        end
        tick();
        idle();
        br_valid = 1; rs1id = 5; rs2id = 0;
        #1;
        nvec++;
        if (stall !== 1'b0 || fa !== 1'b0 || stall_cnt !== 8'd0) begin
            nerr++; $display("FAIL wb_cleared stall=%b fa=%b cnt=%0d want 0/0/0", stall, fa, stall_cnt);
        end
        tick();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 0; wb_valid = 1; rdwb = 0; br_valid = 1;
        #1;
        nvec++;
        if (stall !== 1'b0 || fa !== 1'b0 || fb !== 1'b0) begin
            nerr++; $display("FAIL reg_zero stall=%b fa=%b fb=%b want 0/0/0", stall, fa, fb);
        end
        tick();
        idle();
        br_valid = 1;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL reg_zero_pending stall=%b want 0", stall);
        end
        tick();
    endtask

    task automatic test_set_wins();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 7; kill_valid = 1; kill_rd = 7;
        tick();
        idle();
        br_valid = 1; rs2id = 7;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL set_wins stall=%b want 1", stall);
        end
        tick();
        kill_valid = 1; kill_rd = 7;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL kill_same_cycle stall=%b want 1", stall);
        end
        tick();
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL kill_clears stall=%b want 0", stall);
        end
        m_eval();
        nvec++;
        if ({fa, fb, stall, stall_cnt, stall_err} !== {e_fa, e_fb, e_stall, 8'(mcnt), merr}) begin
            nerr++; $display("FAIL kill_model got=%h want=%h", {fa, fb, stall, stall_cnt, stall_err}, {e_fa, e_fb, e_stall, 8'(mcnt), merr});
        end
        idle();
        tick();
    endtask

    task automatic test_class();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 3; issue_fp = 1;
        tick();
        idle();
        br_valid = 1; rs2id = 3; float_read = 2'b00;
        #1;
        m_eval();
        nvec++;
        if (stall !== e_stall || fb !== 1'b0) begin
            nerr++; $display("FAIL class_int_read stall=%b fb=%b want stall=%b fb=0", stall, fb, e_stall);
        end
        float_read = 2'b01;
        wb_valid = 1; rdwb = 3; fw_wb = 0;
        #1;
        m_eval();
        nvec++;
        if ({fa, fb, stall} !== {e_fa, e_fb, e_stall}) begin
            nerr++; $display("FAIL class_fp_read {fa,fb,stall} got=%b want=%b", {fa, fb, stall}, {e_fa, e_fb, e_stall});
        end
        fw_wb = 1;
        #1;
        m_eval();
        nvec++;
        if ({fa, fb, stall} !== {e_fa, e_fb, e_stall}) begin
            nerr++; $display("FAIL class_fp_wb {fa,fb,stall} got=%b want=%b", {fa, fb, stall}, {e_fa, e_fb, e_stall});
        end
        tick();
        idle();
        wb_valid = 1; rdwb = 3;
        tick();
        idle();
        tick();
    endtask

    task automatic test_saturate();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 9;
        tick();
        idle();
        br_valid = 1; rs1id = 9;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin
                nvec++;
                if (stall_cnt !== 8'd254 || stall_err !== 1'b0) begin
                    nerr++; $display("FAIL sat_254 cnt=%0d err=%b want 254/0", stall_cnt, stall_err);
                end
            end
            if (i == 255) begin
                nvec++;
                if (stall_cnt !== 8'd255 || stall_err !== 1'b1) begin
                    nerr++; $display("FAIL sat_255 cnt=%0d err=%b want 255/1", stall_cnt, stall_err);
                end
            end
        end
        nvec++;
        if (stall_cnt !== 8'd255 || stall_err !== 1'b1 || stall !== 1'b1) begin
            nerr++; $display("FAIL sat_300 cnt=%0d err=%b stall=%b want 255/1/1", stall_cnt, stall_err, stall);
        end
        wb_valid = 1; rdwb = 9;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL sat_release stall=%b want 0", stall);
        end
        tick();
        idle();
        #1;
        nvec++;
        if (stall_cnt !== 8'd0 || stall_err !== 1'b1) begin
            nerr++; $display("FAIL err_sticky cnt=%0d err=%b want 0/1", stall_cnt, stall_err);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        issue_valid = 1; issue_wb = 1; issue_rd = 11;
        tick();
        idle();
        br_valid = 1; rs1id = 11;
        tick();
        tick();
        nvec++;
        if (stall !== 1'b1 || stall_cnt !== 8'd2 || stall_err !== 1'b1) begin
            nerr++; $display("FAIL pre_reset stall=%b cnt=%0d err=%b want 1/2/1", stall, stall_cnt, stall_err);
        end
        #2;
        rst_n = 0;
        m_reset();
        wb_valid = 1; rdwb = 11;
        #1;
        nvec++;
        if ({fa, fb, stall, stall_cnt, stall_err} !== 12'd0) begin
            nerr++; $display("FAIL reset_mid_stall {fa,fb,stall,cnt,err} got=%h want=000", {fa, fb, stall, stall_cnt, stall_err});
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        br_valid = 1; rs1id = 11; rs2id = 7;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL reset_clears_entries stall=%b want 0", stall);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_wb    = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_fp    = 1'($urandom);
            kill_valid  = ($urandom_range(0, 4) == 0);
            kill_rd     = 5'($urandom_range(0, 7));
            kill_fp     = 1'($urandom);
            wb_valid    = ($urandom_range(0, 1) == 1);
            rdwb        = 5'($urandom_range(0, 7));
            fw_wb       = 1'($urandom);
            br_valid    = ($urandom_range(0, 4) != 0);
            rs1id       = 5'($urandom_range(0, 7));
            rs2id       = 5'($urandom_range(0, 7));
            float_read  = 2'($urandom);
            #1;
            m_eval();
            nvec++;
            if ({fa, fb, stall, stall_cnt, stall_err} !== {e_fa, e_fb, e_stall, 8'(mcnt), merr}) begin
                nerr++; $display("FAIL random[%0d] {fa,fb,stall,cnt,err} got=%h want=%h", n, {fa, fb, stall, stall_cnt, stall_err}, {e_fa, e_fb, e_stall, 8'(mcnt), merr});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stall_count();
        test_set_wins();
        test_class();
        test_saturate();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
